// File: rtl/casez_priority_decoder_pkg.sv
// -----------------------------------------------------------------------------
// casez_priority_decoder_pkg
//   Shared definitions for the casez priority decoder slice.
//   - sel_t : the 4-bit decode vector {a,b,c,d}, a is the MSB
//   - PAT_Z : casez mask for the high-priority term {a,b}==2'b11
//   - PAT_Y : casez mask for the low-priority term  {c,d}==2'b11
// -----------------------------------------------------------------------------
package casez_priority_decoder_pkg;

  typedef logic [3:0] sel_t;

  // '?' bits are don't-care positions when these masks are used as casez items.
  localparam sel_t PAT_Z = 4'b11??;
  localparam sel_t PAT_Y = 4'b??11;

endpackage : casez_priority_decoder_pkg

// File: rtl/casez_priority_decode_comb.sv
// -----------------------------------------------------------------------------
// casez_priority_decode_comb
//   Pure combinational decode of sel = {a,b,c,d} into the next-state flags.
//   Build option: macro PARALLEL_CASE_EN
//     undefined (default) : priority decode, z term wins when both terms match
//     defined             : both terms decode independently (sel=4'b1111 -> both)
// Ports
//   sel  input  4  decode vector {a,b,c,d}
//   y_n  output 1  low-priority term {c,d}==2'b11
//   z_n  output 1  high-priority term {a,b}==2'b11
// -----------------------------------------------------------------------------
module casez_priority_decode_comb
  import casez_priority_decoder_pkg::*;
(
  input  sel_t sel,
  output logic y_n,
  output logic z_n
);

`ifdef PARALLEL_CASE_EN
  // Independent terms: no arm suppresses the other.
  always_comb begin
    z_n = 1'b0;
    y_n = 1'b0;
    casez (sel)
      PAT_Z:   z_n = 1'b1;
      default: z_n = 1'b0;
    endcase
    casez (sel)
      PAT_Y:   y_n = 1'b1;
      default: y_n = 1'b0;
    endcase
  end
`else
  // Arm order is the priority: PAT_Z is tried first, so 4'b1111 only raises z.
  always_comb begin
    z_n = 1'b0;
    y_n = 1'b0;
    casez (sel)
      PAT_Z:   z_n = 1'b1;
      PAT_Y:   y_n = 1'b1;
      default: ;
    endcase
  end
`endif

endmodule : casez_priority_decode_comb

// File: rtl/casez_priority_decoder.sv
// -----------------------------------------------------------------------------
// casez_priority_decoder (top)
//   Two-term priority decoder over {a,b,c,d} with an optional output register.
//   Build option: macro PARALLEL_CASE_EN (see casez_priority_decode_comb).
// Parameters
//   OUT_REG  1: y/z registered, one-cycle latency, async active-low clear
//            0: y/z follow the inputs combinationally; clk/rst_n unused
// Ports
//   clk    input  1  rising-edge clock
//   rst_n  input  1  asynchronous active-low reset
//   a..d   input  1  decode vector bits 3..0
//   y      output 1  low-priority flag, {c,d}==2'b11
//   z      output 1  high-priority flag, {a,b}==2'b11
// -----------------------------------------------------------------------------
module casez_priority_decoder
  import casez_priority_decoder_pkg::*;
#(
  parameter int OUT_REG = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic y,
  output logic z
);

  sel_t sel;
  logic y_n;
  logic z_n;

  assign sel = {a, b, c, d};

  casez_priority_decode_comb u_decode (
    .sel (sel),
    .y_n (y_n),
    .z_n (z_n)
  );

  generate
    if (OUT_REG != 0) begin : g_out_reg
      // Reset clears the flags at once and drops whatever was being decoded.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          y <= 1'b0;
          z <= 1'b0;
        end else begin
          y <= y_n;
          z <= z_n;
        end
      end
    end else begin : g_out_comb
      assign y = y_n;
      assign z = z_n;
      // Clock and reset have no load in the combinational build.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
    end
  endgenerate

endmodule : casez_priority_decoder

// File: tb/tb_casez_priority_decoder.sv
// -----------------------------------------------------------------------------
// tb_casez_priority_decoder
//   Bench for casez_priority_decoder: registered instance (OUT_REG=1) checked
//   through an expected-value queue, plus a combinational instance (OUT_REG=0).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_casez_priority_decoder;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUTs
  logic a, b, c, d;
  logic y, z;
  logic a2, b2, c2, d2;
  logic y2, z2;

  casez_priority_decoder #(.OUT_REG(1)) dut (
    .clk (clk), .rst_n (rst_n),
    .a (a), .b (b), .c (c), .d (d),
    .y (y), .z (z)
  );

  casez_priority_decoder #(.OUT_REG(0)) dut_comb (
    .clk (clk), .rst_n (rst_n),
    .a (a2), .b (b2), .c (c2), .d (d2),
    .y (y2), .z (z2)
  );

  // ---------------------------------------------------------------- model
  // Expected {y,z} from the truth table written as explicit code lists.
  function automatic logic [1:0] model(input logic [3:0] s);
    logic yv, zv;
    zv = (s inside {4'hC, 4'hD, 4'hE, 4'hF});
`ifdef PARALLEL_CASE_EN
    yv = (s inside {4'h3, 4'h7, 4'hB, 4'hF});
`else
    yv = (s inside {4'h3, 4'h7, 4'hB});
`endif
    return {yv, zv};
  endfunction

  // ---------------------------------------------------------------- scoreboard
  logic [1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got y,z=%b required y,z=%b", name, act, exp);
    end
  endtask

  // Drive sel on the falling edge, push its expectation, compare after the
  // next rising edge (one-cycle latency).
  task automatic drive(input logic [3:0] s, input string name);
    logic [1:0] e;
    @(negedge clk);
    {a, b, c, d} = s;
    exp_q.push_back(model(s));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got y,z=%b required an entry", name, {y, z});
    end else begin
      e = exp_q.pop_front();
      check(name, {y, z}, e);
    end
  endtask

  task automatic comb_step(input logic [3:0] s, input logic [1:0] exp, input string name);
    {a2, b2, c2, d2} = s;
    #1;
    check(name, {y2, z2}, exp);
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic [3:0] sel;
    logic [1:0] exp;  // {y,z}
  } vec_t;

  vec_t vecs[16];

  // ---------------------------------------------------------------- watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------- test
  initial begin
    for (int i = 0; i < 16; i++) begin
      vecs[i].sel = 4'(i);
      vecs[i].exp = model(4'(i));
    end
    {a, b, c, d} = 4'b1111;
    {a2, b2, c2, d2} = 4'b0000;

    // Reset held with an active input pattern and a running clock.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_hold_0", {y, z}, 2'b00);
    @(negedge clk);
    check("reset_hold_1", {y, z}, 2'b00);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release_first_edge", {y, z}, model(4'b1111));

    // Exhaustive sweep, one code per cycle.
    for (int i = 0; i < 16; i++)
      drive(vecs[i].sel, $sformatf("sweep_sel_%h", vecs[i].sel));

    // Random codes through the scoreboard.
    for (int i = 0; i < 6; i++)
      drive(4'($urandom_range(0, 15)), "random_sel");

    // Overlap code.
`ifdef PARALLEL_CASE_EN
    drive(4'b1111, "overlap_parallel");
    check("overlap_parallel_const", {y, z}, 2'b11);
`else
    drive(4'b1111, "overlap_priority");
    check("overlap_priority_const", {y, z}, 2'b01);
`endif

    // Asynchronous reset between clock edges.
    drive(4'b1100, "async_pre_z");
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_reset_clear", {y, z}, 2'b00);
    @(negedge clk);
    check("async_reset_still_low", {y, z}, 2'b00);
    rst_n = 1'b1;
    drive(4'b0111, "after_async_reset");

    // Combinational build: no clock involvement needed.
    comb_step(4'b0011, 2'b10, "comb_0011");
    comb_step(4'b1100, 2'b01, "comb_1100");
    comb_step(4'b0000, 2'b00, "comb_0000");
`ifdef PARALLEL_CASE_EN
    comb_step(4'b1111, 2'b11, "comb_1111");
`else
    comb_step(4'b1111, 2'b01, "comb_1111");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_casez_priority_decoder
